// File: rtl/demod_scheduler.sv
// Purpose : schedules ASK/AM demodulators; counts low-level ADC samples over a fixed
//           window to classify the signal, waits a settle time, then runs the chosen
//           demodulator for a fixed time before rescanning.
// Latency : all outputs registered; a classification appears the cycle after the last
//           window sample; enables rise the cycle after the last settle cycle.
// Backpr. : none; ad_data is consumed every cycle, start/stop are single-cycle requests
//           (stop wins over start and is honoured in any state).
//
// Ports   : clk, rst_n (async active-low), ad_data[9:0], start, stop ->
//           ask_en, am_en, is_ask, type_valid, type_changed, busy, state[1:0]
// Config  : define DEMOD_SCHED_CONFIRM_EN to accept a window result only when it
//           matches the immediately preceding window result (two-window confirmation).
module demod_scheduler #(
    parameter int unsigned SAMPLE_COUNT        = 10000,
    parameter int unsigned ASK_THRESHOLD       = 2000,
    parameter int unsigned LOW_LEVEL_THRESHOLD = 10,
    parameter int unsigned SETTLE_CYCLES       = 64,
    parameter int unsigned RUN_CYCLES          = 8192000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] ad_data,
    input  logic       start,
    input  logic       stop,
    output logic       ask_en,
    output logic       am_en,
    output logic       is_ask,
    output logic       type_valid,
    output logic       type_changed,
    output logic       busy,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DETECT = 2'd1,
        S_SETTLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    // One phase counter is shared by DETECT, SETTLE and RUN; 24 bits covers RUN_CYCLES.
    localparam logic [23:0] DET_LAST = 24'(SAMPLE_COUNT - 1);
    localparam logic [23:0] SET_LAST = 24'(SETTLE_CYCLES - 1);
    localparam logic [23:0] RUN_LAST = 24'(RUN_CYCLES - 1);

    state_t      state_q;
    logic [23:0] cnt_q;
    logic [15:0] zero_cnt_q;
    logic        ask_en_q;
    logic        am_en_q;
    logic        is_ask_q;
    logic        type_valid_q;
    logic        type_changed_q;
    logic        busy_q;

    logic        zero_hit;
    logic [15:0] zero_cnt_d;
    logic        win_ask;
    logic        win_accept;

    // Zero count including the current sample, saturating at 65535. On the last
    // window cycle this is the final count used for the decision.
    assign zero_hit   = ({22'd0, ad_data} < 32'(LOW_LEVEL_THRESHOLD));
    assign zero_cnt_d = (zero_hit && (zero_cnt_q != 16'hFFFF)) ? zero_cnt_q + 16'd1
                                                               : zero_cnt_q;
    assign win_ask    = ({16'd0, zero_cnt_d} > 32'(ASK_THRESHOLD));

`ifdef DEMOD_SCHED_CONFIRM_EN
    logic pend_vld_q;
    logic pend_ask_q;

    // A window result counts only if the previous window produced the same answer.
    assign win_accept = pend_vld_q && (pend_ask_q == win_ask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q <= 1'b0;
            pend_ask_q <= 1'b0;
        end else if (!stop) begin
            if (state_q == S_IDLE && start) begin
                // Fresh start: the first window may never be accepted on its own.
                pend_vld_q <= 1'b0;
            end else if (state_q == S_DETECT && cnt_q == DET_LAST) begin
                pend_vld_q <= 1'b1;
                pend_ask_q <= win_ask;
            end
        end
    end
`else
    assign win_accept = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= 24'd0;
            zero_cnt_q     <= 16'd0;
            ask_en_q       <= 1'b0;
            am_en_q        <= 1'b0;
            is_ask_q       <= 1'b0;
            type_valid_q   <= 1'b0;
            type_changed_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            type_changed_q <= 1'b0;
            if (stop) begin
                // Abort keeps the last classification so it can be reported after stop.
                state_q    <= S_IDLE;
                busy_q     <= 1'b0;
                ask_en_q   <= 1'b0;
                am_en_q    <= 1'b0;
                cnt_q      <= 24'd0;
                zero_cnt_q <= 16'd0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q    <= S_DETECT;
                            busy_q     <= 1'b1;
                            cnt_q      <= 24'd0;
                            zero_cnt_q <= 16'd0;
                        end
                    end
                    S_DETECT: begin
                        if (cnt_q == DET_LAST) begin
                            cnt_q      <= 24'd0;
                            zero_cnt_q <= 16'd0;
                            // Without acceptance we stay in DETECT and a new window
                            // starts on the next cycle.
                            if (win_accept) begin
                                state_q        <= S_SETTLE;
                                is_ask_q       <= win_ask;
                                type_valid_q   <= 1'b1;
                                type_changed_q <= type_valid_q && (is_ask_q != win_ask);
                            end
                        end else begin
                            cnt_q      <= cnt_q + 24'd1;
                            zero_cnt_q <= zero_cnt_d;
                        end
                    end
                    S_SETTLE: begin
                        if (cnt_q == SET_LAST) begin
                            cnt_q    <= 24'd0;
                            state_q  <= S_RUN;
                            ask_en_q <= is_ask_q;
                            am_en_q  <= !is_ask_q;
                        end else begin
                            cnt_q <= cnt_q + 24'd1;
                        end
                    end
                    S_RUN: begin
                        if (cnt_q == RUN_LAST) begin
                            cnt_q      <= 24'd0;
                            zero_cnt_q <= 16'd0;
                            state_q    <= S_DETECT;
                            ask_en_q   <= 1'b0;
                            am_en_q    <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 24'd1;
                        end
                    end
                    default: begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        ask_en_q <= 1'b0;
                        am_en_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ask_en       = ask_en_q;
    assign am_en        = am_en_q;
    assign is_ask       = is_ask_q;
    assign type_valid   = type_valid_q;
    assign type_changed = type_changed_q;
    assign busy         = busy_q;
    assign state        = state_q;

endmodule

// File: tb/tb_demod_scheduler.sv
// Purpose : directed self-checking bench for demod_scheduler with a short window
//           (16 samples, threshold 4, settle 3, run 10, low level 10).
// Latency : inputs driven on the falling edge, outputs sampled on the falling edge.
// Backpr. : none.
module tb_demod_scheduler;

    logic       clk;
    logic       rst_n;
    logic [9:0] ad_data;
    logic       start;
    logic       stop;
    logic       ask_en;
    logic       am_en;
    logic       is_ask;
    logic       type_valid;
    logic       type_changed;
    logic       busy;
    logic [1:0] state;

    int checks;
    int errors;
    int n;
    logic excl_bad;
    logic en_seen;

    demod_scheduler #(
        .SAMPLE_COUNT       (16),
        .ASK_THRESHOLD      (4),
        .LOW_LEVEL_THRESHOLD(10),
        .SETTLE_CYCLES      (3),
        .RUN_CYCLES         (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ad_data     (ad_data),
        .start       (start),
        .stop        (stop),
        .ask_en      (ask_en),
        .am_en       (am_en),
        .is_ask      (is_ask),
        .type_valid  (type_valid),
        .type_changed(type_changed),
        .busy        (busy),
        .state       (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Background watch: enables must never overlap; en_seen records any enable.
    always @(negedge clk) begin
        if (ask_en && am_en) excl_bad = 1'b1;
        if (ask_en || am_en) en_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present v for n consecutive cycles (one sample per rising edge).
    task automatic drive(input int cyc, input logic [9:0] v);
        for (int i = 0; i < cyc; i++) begin
            ad_data = v;
            step();
        end
    endtask

    // Count consecutive cycles in state st with the given enables; bounded.
    task automatic count_while(input logic [1:0] st, input logic want_ask,
                               input logic want_am, output int cnt);
        cnt = 0;
        while (state == st && ask_en == want_ask && am_en == want_am && cnt < 100) begin
            cnt++;
            step();
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        excl_bad = 1'b0;
        en_seen  = 1'b0;
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        ad_data  = 10'd0;
        #3;
        chk("rst_state", 32'(state), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_outs", 32'({ask_en, am_en, is_ask, type_valid, type_changed}), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("idle_state", 32'(state), 0);

`ifdef DEMOD_SCHED_CONFIRM_EN
        en_seen = 1'b0;
        do_start();
        chk("cf_detect", 32'(state), 1);
        drive(11, 10'd512); drive(5, 10'd9);          // ASK window
        chk("cf_w1_state", 32'(state), 1);
        chk("cf_w1_tv", 32'(type_valid), 0);
        drive(12, 10'd512); drive(4, 10'd9);          // AM window, differs from ASK
        chk("cf_w2_state", 32'(state), 1);
        chk("cf_w2_tv", 32'(type_valid), 0);
        drive(12, 10'd512); drive(4, 10'd9);          // AM again, confirmed
        chk("cf_w3_state", 32'(state), 2);
        chk("cf_w3_is_ask", 32'(is_ask), 0);
        chk("cf_w3_tv", 32'(type_valid), 1);
        chk("cf_w3_tc", 32'(type_changed), 0);
        chk("cf_no_en", 32'(en_seen), 0);
        count_while(2'd2, 1'b0, 1'b0, n);
        chk("cf_settle_len", 32'(n), 3);
        count_while(2'd3, 1'b0, 1'b1, n);
        chk("cf_run_am_len", 32'(n), 10);
        chk("cf_rescan", 32'(state), 1);
`else
        // ASK window: 5 low samples at the end, including the last.
        do_start();
        chk("t1_detect", 32'(state), 1);
        chk("t1_busy", 32'(busy), 1);
        drive(11, 10'd512); drive(5, 10'd9);
        chk("t1_state", 32'(state), 2);
        chk("t1_is_ask", 32'(is_ask), 1);
        chk("t1_tv", 32'(type_valid), 1);
        chk("t1_tc", 32'(type_changed), 0);
        count_while(2'd2, 1'b0, 1'b0, n);
        chk("t1_settle_len", 32'(n), 3);
        count_while(2'd3, 1'b1, 1'b0, n);
        chk("t1_run_ask_len", 32'(n), 10);
        chk("t1_rescan", 32'(state), 1);
        chk("t1_rescan_en", 32'({ask_en, am_en}), 0);

        // AM rescan window: exactly 4 low samples (not above threshold).
        en_seen = 1'b0;
        drive(12, 10'd512); drive(4, 10'd9);
        chk("t2_is_ask", 32'(is_ask), 0);
        chk("t2_tc_pulse", 32'(type_changed), 1);
        step();
        chk("t2_tc_clear", 32'(type_changed), 0);
        count_while(2'd2, 1'b0, 1'b0, n);
        chk("t2_settle_rest", 32'(n), 2);
        chk("t2_no_en_before_run", 32'(en_seen), 0);
        count_while(2'd3, 1'b0, 1'b1, n);
        chk("t2_run_am_len", 32'(n), 10);

        // ASK again, then stop in RUN cycle 5.
        drive(11, 10'd512); drive(5, 10'd9);
        chk("t3_tc_pulse", 32'(type_changed), 1);
        count_while(2'd2, 1'b0, 1'b0, n);
        chk("t3_settle_len", 32'(n), 3);
        repeat (4) step();
        chk("t3_run5_ask", 32'({state, ask_en}), 32'({2'd3, 1'b1}));
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t3_stop_en", 32'({ask_en, am_en}), 0);
        chk("t3_stop_state", 32'(state), 0);
        chk("t3_stop_busy", 32'(busy), 0);
        chk("t3_stop_keep", 32'({is_ask, type_valid}), 3);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("t3_startstop", 32'(state), 0);
        step();
        chk("t3_startstop2", 32'({state, busy}), 0);

        // Reset in the middle of a window discards it.
        do_start();
        drive(8, 10'd9);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_async_state", 32'({state, busy}), 0);
        chk("t4_async_outs", 32'({ask_en, am_en, is_ask, type_valid, type_changed}), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("t4_idle", 32'(state), 0);
        do_start();
        drive(15, 10'd9);
        chk("t4_still_detect", 32'(state), 1);
        drive(1, 10'd9);
        chk("t4_exit", 32'(state), 2);
        chk("t4_cls", 32'({is_ask, type_valid, type_changed}), 32'(3'b110));
        count_while(2'd2, 1'b0, 1'b0, n);
        chk("t4_settle_len", 32'(n), 3);
        count_while(2'd3, 1'b1, 1'b0, n);
        chk("t4_run_len", 32'(n), 10);

        // Samples equal to the low-level threshold are not zero samples.
        drive(16, 10'd10);
        chk("t5_is_ask", 32'(is_ask), 0);
        chk("t5_tc", 32'(type_changed), 1);
`endif
        chk("never_both_en", 32'(excl_bad), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
